// File: rtl/sya_pe_array_os.sv
// Output-stationary NUM_ROW x NUM_COL multiply-accumulate array with input skewing,
// a stall-tolerant valid/ready feed, automatic flush and a row-serial psum drain.
module sya_pe_array_os #(
  parameter int ACT_WIDTH  = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int CHN_WIDTH  = 16,
  parameter int NUM_ROW    = 16,
  parameter int NUM_COL    = 16,
  parameter int PSUM_WIDTH = ACT_WIDTH + WGT_WIDTH + CHN_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          CfgVld,
  output logic                          CfgRdy,
  input  logic [CHN_WIDTH-1:0]          CfgChn,
  input  logic                          CfgSigned,
  input  logic                          InAct_Vld,
  output logic                          InAct_Rdy,
  input  logic [NUM_ROW*ACT_WIDTH-1:0]  InAct,
  input  logic                          InWgt_Vld,
  output logic                          InWgt_Rdy,
  input  logic [NUM_COL*WGT_WIDTH-1:0]  InWgt,
  output logic                          OutPsum_Vld,
  input  logic                          OutPsum_Rdy,
  output logic [NUM_COL*PSUM_WIDTH-1:0] OutPsum,
  output logic                          OutPsum_Last,
  output logic                          Busy
);

  localparam int FLUSH_LEN  = NUM_ROW + NUM_COL - 2;
  localparam int FLUSH_LAST = (FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0;
  localparam int FLUSH_W    = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int ROW_W      = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int MUL_W      = ACT_WIDTH + WGT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COMP  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                 state_r;
  state_e                 stateNxt_s;
  logic [CHN_WIDTH-1:0]   chn_r;
  logic                   signed_r;
  logic [CHN_WIDTH-1:0]   stepCnt_r;
  logic [FLUSH_W-1:0]     flushCnt_r;
  logic [ROW_W-1:0]       rowCnt_r;

  logic                   cfgFire_s;
  logic                   feedRdy_s;
  logic                   fire_s;
  logic                   adv_s;
  logic                   clr_s;
  logic                   lastStep_s;
  logic                   lastRow_s;
  logic                   drainFire_s;

  logic [NUM_ROW*ACT_WIDTH-1:0] actSrc_s;
  logic [NUM_COL*WGT_WIDTH-1:0] wgtSrc_s;

  logic [ACT_WIDTH-1:0]   peAct_s  [NUM_ROW][NUM_COL];
  logic [WGT_WIDTH-1:0]   peWgt_s  [NUM_ROW][NUM_COL];
  logic [PSUM_WIDTH-1:0]  psum_s   [NUM_ROW][NUM_COL];

  // Readys and status decode from registered state only, never from the input valids
  assign CfgRdy       = (state_r == IDLE);
  assign Busy         = (state_r != IDLE);
  assign feedRdy_s    = (state_r == COMP) && (stepCnt_r < chn_r);
  assign InAct_Rdy    = feedRdy_s;
  assign InWgt_Rdy    = feedRdy_s;
  assign cfgFire_s    = CfgVld & CfgRdy;
  assign clr_s        = cfgFire_s;
  assign fire_s       = InAct_Vld & InWgt_Vld & feedRdy_s;
  assign adv_s        = fire_s | (state_r == FLUSH);
  assign lastStep_s   = (stepCnt_r == (chn_r - CHN_WIDTH'(1)));
  assign lastRow_s    = (rowCnt_r == ROW_W'(NUM_ROW - 1));
  assign drainFire_s  = (state_r == DRAIN) & OutPsum_Rdy;
  assign OutPsum_Vld  = (state_r == DRAIN);
  assign OutPsum_Last = (state_r == DRAIN) & lastRow_s;

  // Flush injects zero operands into the skew lines
  assign actSrc_s = (state_r == COMP) ? InAct : '0;
  assign wgtSrc_s = (state_r == COMP) ? InWgt : '0;

  // Next-state decode
  always_comb begin
    stateNxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfgFire_s) begin
          if (CfgChn == '0) begin
            stateNxt_s = DRAIN;
          end else begin
            stateNxt_s = COMP;
          end
        end else begin
          stateNxt_s = IDLE;
        end
      end
      COMP: begin
        if (fire_s && lastStep_s) begin
          stateNxt_s = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
        end else begin
          stateNxt_s = COMP;
        end
      end
      FLUSH: begin
        if (flushCnt_r == FLUSH_W'(FLUSH_LAST)) begin
          stateNxt_s = DRAIN;
        end else begin
          stateNxt_s = FLUSH;
        end
      end
      DRAIN: begin
        if (drainFire_s && lastRow_s) begin
          stateNxt_s = IDLE;
        end else begin
          stateNxt_s = DRAIN;
        end
      end
      default: stateNxt_s = IDLE;
    endcase
  end

  // State register, tile configuration and step/flush/row counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      chn_r      <= '0;
      signed_r   <= 1'b0;
      stepCnt_r  <= '0;
      flushCnt_r <= '0;
      rowCnt_r   <= '0;
    end else begin
      state_r <= stateNxt_s;
      if (cfgFire_s) begin
        chn_r      <= CfgChn;
        signed_r   <= CfgSigned;
        stepCnt_r  <= '0;
        flushCnt_r <= '0;
        rowCnt_r   <= '0;
      end else begin
        if (fire_s) begin
          stepCnt_r <= stepCnt_r + CHN_WIDTH'(1);
        end
        if (state_r == FLUSH) begin
          flushCnt_r <= flushCnt_r + FLUSH_W'(1);
        end
        if (drainFire_s) begin
          rowCnt_r <= lastRow_s ? '0 : rowCnt_r + ROW_W'(1);
        end
      end
    end
  end

  genvar r, c;

  // Row r activations are delayed by r advances so step k reaches PE(r,c) on advance k+r+c
  for (r = 0; r < NUM_ROW; r++) begin : gActSkew
    logic [ACT_WIDTH-1:0] rowSrc_s;
    assign rowSrc_s = actSrc_s[r*ACT_WIDTH +: ACT_WIDTH];
    if (r == 0) begin : gDirect
      assign peAct_s[0][0] = rowSrc_s;
    end else begin : gStages
      logic [ACT_WIDTH-1:0] skew_r [r];
      // Activation delay line, shifts only on array advance
      always_ff @(posedge clk) begin
        if (!rst_n || clr_s) begin
          for (int i = 0; i < r; i++) skew_r[i] <= '0;
        end else if (adv_s) begin
          skew_r[0] <= rowSrc_s;
          for (int i = 1; i < r; i++) skew_r[i] <= skew_r[i-1];
        end
      end
      assign peAct_s[r][0] = skew_r[r-1];
    end
  end

  for (c = 0; c < NUM_COL; c++) begin : gWgtSkew
    logic [WGT_WIDTH-1:0] colSrc_s;
    assign colSrc_s = wgtSrc_s[c*WGT_WIDTH +: WGT_WIDTH];
    if (c == 0) begin : gDirect
      assign peWgt_s[0][0] = colSrc_s;
    end else begin : gStages
      logic [WGT_WIDTH-1:0] skew_r [c];
      // Weight delay line, shifts only on array advance
      always_ff @(posedge clk) begin
        if (!rst_n || clr_s) begin
          for (int i = 0; i < c; i++) skew_r[i] <= '0;
        end else if (adv_s) begin
          skew_r[0] <= colSrc_s;
          for (int i = 1; i < c; i++) skew_r[i] <= skew_r[i-1];
        end
      end
      assign peWgt_s[0][c] = skew_r[c-1];
    end
  end

  for (r = 0; r < NUM_ROW; r++) begin : gRow
    for (c = 0; c < NUM_COL; c++) begin : gCol
      logic                  aTop_s;
      logic                  wTop_s;
      logic [MUL_W-1:0]      aExt_s;
      logic [MUL_W-1:0]      wExt_s;
      logic [MUL_W-1:0]      mul_s;
      logic [PSUM_WIDTH-1:0] prod_s;
      logic [PSUM_WIDTH-1:0] acc_r;

      // A MUL_W-bit product holds every signed or unsigned result exactly; widen afterwards
      assign aTop_s = signed_r & peAct_s[r][c][ACT_WIDTH-1];
      assign wTop_s = signed_r & peWgt_s[r][c][WGT_WIDTH-1];
      assign aExt_s = {{WGT_WIDTH{aTop_s}}, peAct_s[r][c]};
      assign wExt_s = {{ACT_WIDTH{wTop_s}}, peWgt_s[r][c]};
      assign mul_s  = aExt_s * wExt_s;
      assign prod_s = {{(PSUM_WIDTH-MUL_W){signed_r & mul_s[MUL_W-1]}}, mul_s};

      // Wrapping accumulator, held while the array is stalled
      always_ff @(posedge clk) begin
        if (!rst_n || clr_s) begin
          acc_r <= '0;
        end else if (adv_s) begin
          acc_r <= acc_r + prod_s;
        end
      end
      assign psum_s[r][c] = acc_r;

      if (c < NUM_COL - 1) begin : gActFwd
        logic [ACT_WIDTH-1:0] fwd_r;
        // Eastbound activation hop
        always_ff @(posedge clk) begin
          if (!rst_n || clr_s) begin
            fwd_r <= '0;
          end else if (adv_s) begin
            fwd_r <= peAct_s[r][c];
          end
        end
        assign peAct_s[r][c+1] = fwd_r;
      end

      if (r < NUM_ROW - 1) begin : gWgtFwd
        logic [WGT_WIDTH-1:0] fwd_r;
        // Southbound weight hop
        always_ff @(posedge clk) begin
          if (!rst_n || clr_s) begin
            fwd_r <= '0;
          end else if (adv_s) begin
            fwd_r <= peWgt_s[r][c];
          end
        end
        assign peWgt_s[r+1][c] = fwd_r;
      end
    end
  end

  // Present the selected psum row; zero whenever no beat is offered
  always_comb begin
    OutPsum = '0;
    if (state_r == DRAIN) begin
      for (int i = 0; i < NUM_COL; i++) begin
        OutPsum[i*PSUM_WIDTH +: PSUM_WIDTH] = psum_s[rowCnt_r][i];
      end
    end else begin
      OutPsum = '0;
    end
  end

endmodule

// File: doc/sya_pe_array_os.md
# sya_pe_array_os

Output-stationary systolic PE array of NUM_ROW×NUM_COL multiply-accumulate cells with built-in input skewing, a stall-tolerant valid/ready feed, automatic pipeline flush, and a row-serial psum drain. It replaces the bare PE bank in the SYA datapath. The activation and weight buffers feed it unskewed vectors, and the psum writeback consumes one output row per handshake.

## Interface
- ACT_WIDTH, 8: activation bits
- WGT_WIDTH, 8: weight bits
- CHN_WIDTH, 16: accumulation-count field width
- NUM_ROW, 16: array rows (≥1)
- NUM_COL, 16: array columns (≥1)
- PSUM_WIDTH, ACT_WIDTH+WGT_WIDTH+CHN_WIDTH: accumulator bits
- Reset: synchronous, active-low.

- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous active-low reset
- CfgVld  in  1  config valid
- CfgRdy  out  1  config ready, =1 only in IDLE
- CfgChn  in  CHN_WIDTH  K, accumulation steps for this tile
- CfgSigned  in  1  1: two's-complement operands; 0: unsigned
- InAct_Vld / InAct_Rdy  in / out  1  activation handshake
- InAct  in  NUM_ROW*ACT_WIDTH  one activation per row, row r at bits [r*ACT_WIDTH +: ACT_WIDTH]
- InWgt_Vld / InWgt_Rdy  in / out  1  weight handshake
- InWgt  in  NUM_COL*WGT_WIDTH  one weight per column, same packing
- OutPsum_Vld / OutPsum_Rdy  out / in  1  drain handshake
- OutPsum  out  NUM_COL*PSUM_WIDTH  one psum row, column c at [c*PSUM_WIDTH +: PSUM_WIDTH]
- OutPsum_Last  out  1  marks the final row beat
- Busy  out  1  state≠IDLE

## Operation
- FSM states: IDLE, COMP, FLUSH, DRAIN.
- **IDLE → COMP** on CfgVld&CfgRdy.
  - Latch K and CfgSigned.
  - Clear all psums, skew registers, inter-PE registers, and the step/row counters.
  - If K=0, go to DRAIN instead; all psums drain as 0.
- **COMP:**
  - InAct_Rdy = InWgt_Rdy = 1 while step_cnt < K; both are 0 in every other state.
  - fire = InAct_Vld & InWgt_Vld & ready. Both sides are consumed together; a one-sided valid consumes nothing.
  - On fire, step_cnt increments. After the K-th fire, go to FLUSH.
- **Array advance:**
  - Global enable adv = fire | (state==FLUSH). With adv=0 the array holds every register, so a stall is invisible in the results.
  - Row r activation passes through r skew stages; column c weight passes through c skew stages.
  - Each PE forwards act east and wgt south through one register each.
  - Step k therefore meets at PE(r,c) on advance number k+r+c.
- **PE arithmetic:**
  - psum += ext(act×wgt). The product is sign-extended if CfgSigned, else zero-extended, to PSUM_WIDTH.
  - Accumulation wraps modulo 2^PSUM_WIDTH, with no saturation.
  - FLUSH injects zero act/wgt.
- **FLUSH:** exactly NUM_ROW+NUM_COL−2 cycles, counted by a flush counter, then DRAIN. With a 0-length flush (1×1 array), go COMP → DRAIN directly.
- **DRAIN:**
  - OutPsum_Vld=1; OutPsum = psum row row_cnt.
  - Row advances on OutPsum_Rdy.
  - OutPsum_Last = (row_cnt==NUM_ROW−1).
  - The handshake on the last row goes to IDLE.
- **Config outside IDLE:** ignored (CfgRdy=0). Input valids outside COMP are ignored.
- **Reset mid-operation:** rst_n=0 at any state → IDLE on the next edge, with all storage cleared. Partial tiles are discarded.

## Timing
- **Reset values:**
  - CfgRdy=1, Busy=0.
  - InAct_Rdy=InWgt_Rdy=0.
  - OutPsum_Vld=0, OutPsum_Last=0, OutPsum=0.
  - OutPsum reads 0 whenever OutPsum_Vld=0.
- **Config:** accepted in cycle t; InAct_Rdy=1 from t+1 (K≥1).
- **Last fire to first output:** with the last fire in cycle t, FLUSH spans t+1..t+NUM_ROW+NUM_COL−2. OutPsum_Vld rises at t+NUM_ROW+NUM_COL−1, which is t+31 at the defaults.
- **Drain:** NUM_ROW beats minimum, with no bubbles under constant Rdy. OutPsum and Last hold stable while Vld&!Rdy.
- **End of tile:** CfgRdy=1 the cycle after the last drain handshake. Back-to-back tiles therefore have 1 idle cycle.
- **All outputs are registered,** or are decoded only from registered state. There is no combinational path from the input valids to the readys.

## Test plan
- **Latency:** defaults, K=1, CfgSigned=0, act all 1, wgt all 2, valids tied high → all psums=2; OutPsum_Vld rises exactly 31 cycles after the fire; 16 beats; Last only on beat 16.
- **Signed and unsigned:** K=3 signed with act=wgt=−128 → every psum 49152. K=2 unsigned with act=wgt=255 → every psum 130050.
- **Random with stalls:** K=16, random signed 16×16 A and B, independent random gaps on InAct_Vld/InWgt_Vld → drained rows equal golden A·B, bit-exact, and equal to the stall-free run.
- **Backpressure:** OutPsum_Rdy low for 5 cycles while row 3 is presented → row 3 data and Vld held constant; rows delivered in order 0..15; CfgRdy returns 1 one cycle after the row 15 handshake.
- **K=0 and ignored inputs:** K=0 → DRAIN with no FLUSH; 16 rows of 0. CfgVld pulsed during DRAIN → ignored, and no second tile starts.
- **Reset mid-tile:** rst_n low for 1 cycle after 5 of 8 fires → next cycle Busy=0, CfgRdy=1, OutPsum_Vld=0. A new K=1 tile (act 3, wgt 4) then yields all psums=12 with no residue.
